// File: rtl/sram_rw_port_ctrl.sv
// Requester-side controller for a single-port RW SRAM macro with in-order, credit-limited read responses.
// Optional macro SRAM_CTRL_INIT_CLEAR_EN adds a post-reset sweep that zeroes every word before accepting requests.
module sram_rw_port_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state, state_nxt;
  logic              rd_pend;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_q0, fifo_q1;
  logic              run, req_fire, rd_fire, push, pop;
  logic [1:0]        occ;

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("DEPTH must equal 2**ADDR_W");
  end

  assign run       = (state == ST_RUN);
  assign init_done = run;

  // Credit counts the read whose data lands next edge plus queued entries, net of this cycle's pop.
  assign push      = rd_pend;
  assign pop       = (fifo_cnt != 2'd0) & resp_ready;
  assign occ       = {1'b0, rd_pend} + fifo_cnt - {1'b0, pop};
  assign req_ready = run & (req_write | (occ < 2'd2));
  assign req_fire  = req_valid & req_ready;
  assign rd_fire   = req_fire & ~req_write;

  assign resp_valid = (fifo_cnt != 2'd0);
  assign resp_rdata = resp_valid ? fifo_q0 : '0;

`ifdef SRAM_CTRL_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  clr_addr <= '0;
    else if (state == ST_INIT)  clr_addr <= clr_addr + 1'b1;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_INIT: begin
`ifdef SRAM_CTRL_INIT_CLEAR_EN
        // Sweep write is gated by reset so the port stays quiet while reset is held.
        mem_en    = ~reset;
        mem_wmode = ~reset;
        mem_addr  = reset ? '0 : clr_addr;
        if (clr_addr == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
`else
        state_nxt = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (req_fire) begin
          mem_en    = 1'b1;
          mem_wmode = req_write;
          mem_addr  = req_addr;
          mem_wdata = req_wdata;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Read-data capture stage: SRAM output is valid only in the cycle after a read fires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rd_pend <= rd_fire;
      if (push & ~pop)      fifo_cnt <= fifo_cnt + 2'd1;
      else if (pop & ~push) fifo_cnt <= fifo_cnt - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push & ~pop) begin
      if (fifo_cnt == 2'd0) fifo_q0 <= mem_rdata;
      else                  fifo_q1 <= mem_rdata;
    end else if (push & pop) begin
      if (fifo_cnt == 2'd1) begin
        fifo_q0 <= mem_rdata;
      end else begin
        fifo_q0 <= fifo_q1;
        fifo_q1 <= mem_rdata;
      end
    end else if (pop) begin
      fifo_q0 <= fifo_q1;
    end
  end

endmodule
